game_countdown_timer: RTL and testbench
=======================================

Name: game_countdown_timer

Overview:
- Round timer for the whack-a-mole game, clocked from the generated base clock domain.
- Divides clk_base down to a seconds tick and counts a game round down from GAME_SECONDS to 0.
- Drives two BCD digits for the display stage and a one-cycle time_up pulse for the game FSM.
- Supports start/restart and pause.

Parameters:
- BASE_FREQ, 30_000_000: clk_base frequency in Hz.
- TICK_FREQ, 1: countdown tick rate in Hz. DIV = BASE_FREQ/TICK_FREQ must be an integer ≥ 2.
- GAME_SECONDS, 60: round length in ticks. Legal range is 1..99.

Ports:
- clk_base  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high; highest priority.
- start  in  1  single-cycle request: load the timer and run; restarts from any state.
- pause  in  1  level; while high in RUN the countdown freezes.
- time_tens  out  4  BCD tens digit of remaining count.
- time_ones  out  4  BCD ones digit of remaining count.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSED.
- tick  out  1  one-cycle pulse per countdown decrement.
- time_up  out  1  one-cycle pulse when count reaches 0.
- done  out  1  level, high in DONE.

Behaviour:
- All outputs are registered.
- Reset (rst sampled high):
  - state = IDLE, prescaler p = 0.
  - Digits = BCD(GAME_SECONDS); e.g. 60 gives tens=6, ones=0.
  - running = paused = tick = time_up = done = 0.
- Prescaler p is $clog2(DIV) bits wide and counts 0..DIV-1.
- States and transitions (priority: rst > start > pause > tick):
  - IDLE: holds. start → RUN with p = 0 and digits reloaded.
  - RUN, advancing:
    - p increments each cycle.
    - When p == DIV-1: p wraps to 0, tick = 1 next cycle, and the BCD count decrements on that same edge.
    - First tick appears DIV cycles after the edge that sampled start.
  - BCD decrement:
    - ones == 0 → ones = 9, tens = tens − 1.
    - Otherwise ones = ones − 1.
  - Final decrement (count 1 → 0):
    - Same edge: state → DONE, time_up = 1 for one cycle (coincident with tick), done = 1, running = 0.
  - RUN with pause sampled high: → PAUSED; p and count do not advance on that edge.
  - PAUSED:
    - p and count hold; paused = 1, running = 0.
    - pause sampled low → RUN; p still holds on that edge.
    - A pause held high for N sampled cycles therefore delays the next tick by exactly N+1 cycles.
  - DONE:
    - Holds with digits = 0/0 and done = 1.
    - Never decrements or wraps below 0.
    - start → RUN with reload; done clears on the same edge.
- start in RUN or PAUSED:
  - Reload digits, p = 0, state RUN, paused cleared.
  - No tick or time_up on that edge, even if p == DIV-1 or the count is 1 (start wins over the final tick).
- start with pause high:
  - Enters RUN on that edge.
  - Next edge goes to PAUSED if pause is still high.
- rst mid-operation: returns to reset values on the next edge regardless of state or inputs.
- tick and time_up are never asserted outside the cycle following a prescaler wrap in RUN.
- Elaboration-time checks: GAME_SECONDS outside 1..99, or DIV < 2, or BASE_FREQ % TICK_FREQ != 0 → $error.

Test Plan:
All scenarios use BASE_FREQ=100, TICK_FREQ=10 (DIV=10), GAME_SECONDS=12.
1. Reset: rst high 3 cycles → tens=1, ones=2, running=0, done=0, tick=0, time_up=0; holds in IDLE for 50 cycles with no tick.
2. Full round:
   - start pulse at cycle 0 → running=1 at cycle 1.
   - Ticks at cycles 10, 20, …, 120, each one cycle wide.
   - At cycle 120: time_up=1 for one cycle, digits 0/0, done=1, running=0.
   - No further tick over 100 extra cycles.
3. BCD borrow:
   - Count shows 12 → 11 → 10 at ticks 1–2.
   - Tick 3 → tens=0, ones=9.
   - Tick 12 → 0/0.
4. Pause:
   - pause high for 25 cycles starting 5 cycles into a tick period.
   - paused=1 and running=0 throughout; digits frozen.
   - Next tick arrives 26 cycles later than unpaused.
5. Restart:
   - start at count 7 (tens=0, ones=7) → digits 1/2 next edge.
   - Next tick exactly 10 cycles later; no time_up.
   - start in DONE → done=0 and a full 120-cycle round.
6. Edge events:
   - start on the same cycle as the final wrap (count 1, p=9) → no time_up, digits 1/2, running=1.
   - rst asserted mid-run at count 5 → next edge all outputs at reset values.

Source files
------------

// File: rtl/game_countdown_timer.sv
// Whack-a-mole round timer. Prescales clk_base down to a countdown tick and
// counts GAME_SECONDS down to zero in two BCD digits, with start/restart and pause.
module game_countdown_timer #(
  parameter int BASE_FREQ    = 30_000_000,
  parameter int TICK_FREQ    = 1,
  parameter int GAME_SECONDS = 60
) (
  input  logic       clk_base,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic       running,
  output logic       paused,
  output logic       tick,
  output logic       time_up,
  output logic       done
);

  localparam int DIV = (TICK_FREQ > 0) ? (BASE_FREQ / TICK_FREQ) : 0;
  localparam int REM = (TICK_FREQ > 0) ? (BASE_FREQ % TICK_FREQ) : 1;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] P_LAST    = PW'(DIV - 1);
  localparam logic [3:0]    INIT_TENS = 4'(GAME_SECONDS / 10);
  localparam logic [3:0]    INIT_ONES = 4'(GAME_SECONDS % 10);

  generate
    if (GAME_SECONDS < 1 || GAME_SECONDS > 99) begin : g_bad_seconds
      $error("game_countdown_timer: GAME_SECONDS must be in 1..99");
    end
    if (DIV < 2 || REM != 0) begin : g_bad_div
      $error("game_countdown_timer: BASE_FREQ/TICK_FREQ must be an integer >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t        state_r, state_n;
  logic [PW-1:0] p_r, p_n;
  logic [3:0]    tens_n, ones_n;
  logic          tick_n, time_up_n, running_n, paused_n, done_n;
  logic          wrap_s, last_s;

  assign wrap_s = (p_r == P_LAST);
  assign last_s = (time_tens == 4'd0) && (time_ones == 4'd1);

  // State, prescaler and BCD count registers
  always_ff @(posedge clk_base) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      p_r       <= '0;
      time_tens <= INIT_TENS;
      time_ones <= INIT_ONES;
    end else begin
      state_r   <= state_n;
      p_r       <= p_n;
      time_tens <= tens_n;
      time_ones <= ones_n;
    end
  end

  // Next state; start overrides everything, including the final wrap
  always_comb begin
    state_n   = state_r;
    p_n       = p_r;
    tens_n    = time_tens;
    ones_n    = time_ones;
    tick_n    = 1'b0;
    time_up_n = 1'b0;
    if (start) begin
      state_n = ST_RUN;
      p_n     = '0;
      tens_n  = INIT_TENS;
      ones_n  = INIT_ONES;
    end else begin
      case (state_r)
        ST_IDLE: state_n = ST_IDLE;
        ST_RUN: begin
          if (pause) begin
            state_n = ST_PAUSED;
          end else if (wrap_s) begin
            p_n    = '0;
            tick_n = 1'b1;
            if (time_ones == 4'd0) begin
              ones_n = 4'd9;
              tens_n = time_tens - 4'd1;
            end else begin
              ones_n = time_ones - 4'd1;
            end
            if (last_s) begin
              state_n   = ST_DONE;
              time_up_n = 1'b1;
            end else begin
              state_n = ST_RUN;
            end
          end else begin
            p_n = p_r + PW'(1);
          end
        end
        // Resuming does not advance p on the release edge
        ST_PAUSED: begin
          if (pause) begin
            state_n = ST_PAUSED;
          end else begin
            state_n = ST_RUN;
          end
        end
        ST_DONE: state_n = ST_DONE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Status levels decoded from the state being entered
  always_comb begin
    running_n = 1'b0;
    paused_n  = 1'b0;
    done_n    = 1'b0;
    case (state_n)
      ST_RUN:    running_n = 1'b1;
      ST_PAUSED: paused_n  = 1'b1;
      ST_DONE:   done_n    = 1'b1;
      default:   running_n = 1'b0;
    endcase
  end

  // Output registers
  always_ff @(posedge clk_base) begin
    if (rst) begin
      running <= 1'b0;
      paused  <= 1'b0;
      done    <= 1'b0;
      tick    <= 1'b0;
      time_up <= 1'b0;
    end else begin
      running <= running_n;
      paused  <= paused_n;
      done    <= done_n;
      tick    <= tick_n;
      time_up <= time_up_n;
    end
  end

endmodule

// File: tb/tb_game_countdown_timer.sv
// Scoreboard bench for game_countdown_timer (DIV=10, 12-tick round): expected
// tick events are queued when a round is started and popped as ticks appear.
module tb_game_countdown_timer;

  logic       clk_base = 1'b0;
  logic       rst, start, pause;
  logic [3:0] time_tens, time_ones;
  logic       running, paused, tick, time_up, done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         at;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       up;
  } exp_t;

  exp_t sb[$];

  game_countdown_timer #(
    .BASE_FREQ   (100),
    .TICK_FREQ   (10),
    .GAME_SECONDS(12)
  ) dut (
    .clk_base (clk_base),
    .rst      (rst),
    .start    (start),
    .pause    (pause),
    .time_tens(time_tens),
    .time_ones(time_ones),
    .running  (running),
    .paused   (paused),
    .tick     (tick),
    .time_up  (time_up),
    .done     (done)
  );

  always #5 clk_base = ~clk_base;

  task automatic step();
    @(posedge clk_base);
    #1;
  endtask

  // Queue ticks 1..last_j of a round whose start was sampled at edge k0
  task automatic push_round(input int k0, input int last_j);
    exp_t e;
    for (int j = 1; j <= last_j; j++) begin
      e.at   = k0 + 10 * j;
      e.tens = 4'((12 - j) / 10);
      e.ones = 4'((12 - j) % 10);
      e.up   = (j == 12);
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    int nt;
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    total++;
    if ({time_tens, time_ones, running, paused, done, tick, time_up} !== {4'd1, 4'd2, 5'b00000}) begin
      bad++;
      $display("FAIL reset_values got tens=%0d ones=%0d run=%0b pau=%0b done=%0b tick=%0b up=%0b, expected 1/2 and all flags 0",
               time_tens, time_ones, running, paused, done, tick, time_up);
    end
    nt = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (tick !== 1'b0 || time_up !== 1'b0 || running !== 1'b0) nt++;
    end
    total++;
    if (nt != 0 || time_tens !== 4'd1 || time_ones !== 4'd2) begin
      bad++;
      $display("FAIL idle_hold got activity=%0d tens=%0d ones=%0d, expected 0 and 1/2", nt, time_tens, time_ones);
    end
  endtask

  task automatic test_full_round();
    exp_t e;
    sb.delete();
    start = 1'b1; step(); start = 1'b0;
    push_round(0, 12);
    total++;
    if (running !== 1'b1 || tick !== 1'b0 || time_tens !== 4'd1 || time_ones !== 4'd2) begin
      bad++;
      $display("FAIL round_start got run=%0b tick=%0b tens=%0d ones=%0d, expected 1 0 1 2", running, tick, time_tens, time_ones);
    end
    for (int k = 1; k <= 220; k++) begin
      step();
      if (tick === 1'b1 || time_up === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL round_extra_tick k=%0d got tick=%0b up=%0b, expected no tick", k, tick, time_up);
        end else begin
          e = sb.pop_front();
          if (k != e.at || tick !== 1'b1 || time_up !== e.up || time_tens !== e.tens || time_ones !== e.ones) begin
            bad++;
            $display("FAIL round_tick k=%0d tick=%0b up=%0b digits=%0d/%0d, expected k=%0d up=%0b digits=%0d/%0d",
                     k, tick, time_up, time_tens, time_ones, e.at, e.up, e.tens, e.ones);
          end
        end
      end
      if (k == 30) begin
        total++;
        if (time_tens !== 4'd0 || time_ones !== 4'd9) begin
          bad++;
          $display("FAIL bcd_borrow got %0d/%0d, expected 0/9", time_tens, time_ones);
        end
      end
      if (k == 120 || k == 121 || k == 220) begin
        total++;
        if (done !== 1'b1 || running !== 1'b0 || time_tens !== 4'd0 || time_ones !== 4'd0) begin
          bad++;
          $display("FAIL round_done k=%0d got done=%0b run=%0b digits=%0d/%0d, expected 1 0 0/0", k, done, running, time_tens, time_ones);
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL round_missed got %0d ticks outstanding, expected 0", sb.size());
    end
  endtask

  task automatic test_pause();
    exp_t e;
    sb.delete();
    start = 1'b1; step(); start = 1'b0;
    e.at = 36; e.tens = 4'd1; e.ones = 4'd1; e.up = 1'b0; sb.push_back(e);
    e.at = 46; e.tens = 4'd1; e.ones = 4'd0; e.up = 1'b0; sb.push_back(e);
    for (int k = 1; k <= 50; k++) begin
      step();
      if (tick === 1'b1 || time_up === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL pause_extra_tick k=%0d got tick=%0b up=%0b, expected no tick", k, tick, time_up);
        end else begin
          e = sb.pop_front();
          if (k != e.at || time_up !== e.up || time_tens !== e.tens || time_ones !== e.ones) begin
            bad++;
            $display("FAIL pause_tick k=%0d up=%0b digits=%0d/%0d, expected k=%0d up=%0b digits=%0d/%0d",
                     k, time_up, time_tens, time_ones, e.at, e.up, e.tens, e.ones);
          end
        end
      end
      if (k >= 6 && k <= 30) begin
        total++;
        if (paused !== 1'b1 || running !== 1'b0 || time_tens !== 4'd1 || time_ones !== 4'd2) begin
          bad++;
          $display("FAIL pause_hold k=%0d got pau=%0b run=%0b digits=%0d/%0d, expected 1 0 1/2", k, paused, running, time_tens, time_ones);
        end
      end
      if (k == 31) begin
        total++;
        if (paused !== 1'b0 || running !== 1'b1) begin
          bad++;
          $display("FAIL pause_resume got pau=%0b run=%0b, expected 0 1", paused, running);
        end
      end
      if (k == 5) pause = 1'b1;
      if (k == 30) pause = 1'b0;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL pause_missed got %0d ticks outstanding, expected 0", sb.size());
    end
  endtask

  task automatic test_restart();
    exp_t e;
    sb.delete();
    start = 1'b1; step(); start = 1'b0;
    push_round(0, 12);
    for (int k = 1; k <= 310; k++) begin
      step();
      if (tick === 1'b1 || time_up === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL restart_extra_tick k=%0d got tick=%0b up=%0b, expected no tick", k, tick, time_up);
        end else begin
          e = sb.pop_front();
          if (k != e.at || time_up !== e.up || time_tens !== e.tens || time_ones !== e.ones) begin
            bad++;
            $display("FAIL restart_tick k=%0d up=%0b digits=%0d/%0d, expected k=%0d up=%0b digits=%0d/%0d",
                     k, time_up, time_tens, time_ones, e.at, e.up, e.tens, e.ones);
          end
        end
      end
      if (k == 50) begin
        total++;
        if (time_tens !== 4'd0 || time_ones !== 4'd7) begin
          bad++;
          $display("FAIL restart_precount got %0d/%0d, expected 0/7", time_tens, time_ones);
        end
        start = 1'b1;
      end
      if (k == 51) begin
        start = 1'b0;
        total++;
        if (time_tens !== 4'd1 || time_ones !== 4'd2 || running !== 1'b1 || tick !== 1'b0) begin
          bad++;
          $display("FAIL restart_reload got %0d/%0d run=%0b tick=%0b, expected 1/2 1 0", time_tens, time_ones, running, tick);
        end
        sb.delete();
        push_round(51, 12);
      end
      if (k == 175) begin
        total++;
        if (done !== 1'b1 || running !== 1'b0 || time_tens !== 4'd0 || time_ones !== 4'd0) begin
          bad++;
          $display("FAIL restart_done got done=%0b run=%0b digits=%0d/%0d, expected 1 0 0/0", done, running, time_tens, time_ones);
        end
      end
      if (k == 180) start = 1'b1;
      if (k == 181) begin
        start = 1'b0;
        total++;
        if (done !== 1'b0 || running !== 1'b1 || time_tens !== 4'd1 || time_ones !== 4'd2 || sb.size() != 0) begin
          bad++;
          $display("FAIL restart_from_done got done=%0b run=%0b digits=%0d/%0d pending=%0d, expected 0 1 1/2 0",
                   done, running, time_tens, time_ones, sb.size());
        end
        sb.delete();
        push_round(181, 12);
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL restart_missed got %0d ticks outstanding, expected 0", sb.size());
    end
  endtask

  task automatic test_edge_events();
    exp_t e;
    sb.delete();
    start = 1'b1; step(); start = 1'b0;
    push_round(0, 11);
    for (int k = 1; k <= 230; k++) begin
      step();
      if (tick === 1'b1 || time_up === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL edge_extra_tick k=%0d got tick=%0b up=%0b, expected no tick", k, tick, time_up);
        end else begin
          e = sb.pop_front();
          if (k != e.at || time_up !== e.up || time_tens !== e.tens || time_ones !== e.ones) begin
            bad++;
            $display("FAIL edge_tick k=%0d up=%0b digits=%0d/%0d, expected k=%0d up=%0b digits=%0d/%0d",
                     k, time_up, time_tens, time_ones, e.at, e.up, e.tens, e.ones);
          end
        end
      end
      if (k == 119) start = 1'b1;
      if (k == 120) begin
        start = 1'b0;
        total++;
        if (time_up !== 1'b0 || tick !== 1'b0 || done !== 1'b0 || running !== 1'b1 ||
            time_tens !== 4'd1 || time_ones !== 4'd2 || sb.size() != 0) begin
          bad++;
          $display("FAIL start_beats_final got up=%0b tick=%0b done=%0b run=%0b digits=%0d/%0d pending=%0d, expected 0 0 0 1 1/2 0",
                   time_up, tick, done, running, time_tens, time_ones, sb.size());
        end
        sb.delete();
        push_round(120, 12);
      end
      if (k == 192) begin
        total++;
        if (time_tens !== 4'd0 || time_ones !== 4'd5) begin
          bad++;
          $display("FAIL rst_precount got %0d/%0d, expected 0/5", time_tens, time_ones);
        end
        rst = 1'b1; start = 1'b1; pause = 1'b1;
      end
      if (k == 193) begin
        rst = 1'b0; start = 1'b0; pause = 1'b0;
        total++;
        if ({time_tens, time_ones, running, paused, done, tick, time_up} !== {4'd1, 4'd2, 5'b00000}) begin
          bad++;
          $display("FAIL rst_midrun got tens=%0d ones=%0d run=%0b pau=%0b done=%0b tick=%0b up=%0b, expected 1/2 and all flags 0",
                   time_tens, time_ones, running, paused, done, tick, time_up);
        end
        sb.delete();
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    test_reset();
    test_full_round();
    test_pause();
    test_restart();
    test_edge_events();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
